// File: rtl/sample_decimator.sv
// sample_decimator: keeps every DECIM_FACTOR-th valid sample (window sum when SAMPLE_DECIMATOR_ACCUM_EN is defined) in a FWFT FIFO.
// Latency: a kept sample is presented on out_data/out_valid one cycle after its input edge.
// Backpressure: the input is never stalled; a kept sample that meets a full FIFO with no pop is dropped and counted.
module sample_decimator #(
    parameter int DECIM_FACTOR = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in,
    input  logic        in_valid,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic [15:0] drop_count
);
    localparam int PW = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM_FACTOR - 1);

    logic [PW-1:0] phase;
    logic          keep;
    logic          pop;
    logic          full;
    logic [31:0]   keep_val;

    assign keep = in_valid && (phase == LAST_PHASE);
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (in_valid) begin
            phase <= keep ? '0 : phase + 1'b1;
        end
    end

`ifdef SAMPLE_DECIMATOR_ACCUM_EN
    logic [31:0] acc;

    // The current sample is folded in combinationally so the keep value covers the whole window.
    assign keep_val = acc + in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (in_valid) begin
            acc <= keep ? '0 : keep_val;
        end
    end
`else
    assign keep_val = in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (keep && full && !pop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    sample_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (keep),
        .push_data (keep_val),
        .pop       (pop),
        .head      (out_data),
        .not_empty (out_valid),
        .full      (full)
    );
endmodule

// sample_fifo: generic first-word-fall-through FIFO; head is the oldest entry whenever not_empty.
// Latency: a push is visible at head one cycle later when the FIFO was empty.
// Backpressure: push is ignored when full unless a pop frees the slot in the same cycle.
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign do_pop    = pop && not_empty;
    assign do_push   = push && (!full || do_pop);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
